// File: rtl/framer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : framer_pkg
// Brief    : Shared types and constants for the axis_framer stream framer.
// Revision : 1.0 - initial release
// ============================================================================
package framer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        TRAILER = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;

    // Header layout: {zeros, seq[15:0], payload_len[15:0]}
    localparam int SEQ_LSB = 16;
    localparam int LEN_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_out_reg
// Brief    : AXI-Stream output holding register; loads only when empty or
//            when the current word is being accepted downstream.
// Revision : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    input  logic             i_tready,
    output logic             o_tvalid,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_load_ok
);

    logic             r_tvalid;
    logic [WIDTH-1:0] r_tdata;
    logic             r_tlast;

    assign o_load_ok = !r_tvalid || i_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (i_load && o_load_ok) begin
            r_tvalid <= i_valid;
            r_tdata  <= i_data;
            r_tlast  <= i_last;
        end
    end

    assign o_tvalid = r_tvalid;
    assign o_tdata  = r_tdata;
    assign o_tlast  = r_tlast;

endmodule
`default_nettype wire

// File: rtl/axis_framer.sv
`default_nettype none
// ============================================================================
// Module   : axis_framer
// Brief    : Wraps a payload stream into frames of SYNC, HEADER and
//            PAYLOAD_LEN words; optional checksum trailer under
//            AXIS_FRAMER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_framer
    import framer_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          PAYLOAD_LEN = 8,
    parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [15:0]      frame_count
);

    localparam logic [15:0] c_LEN      = 16'(PAYLOAD_LEN);
    localparam logic [15:0] c_LAST_IDX = 16'(PAYLOAD_LEN - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_word_cnt;
    logic [15:0]      r_seq;
    logic [15:0]      r_frame_count;
    logic             w_load_ok;
    logic             w_load;
    logic             w_ld_valid;
    logic             w_ld_last;
    logic [WIDTH-1:0] w_ld_data;
    logic [WIDTH-1:0] w_header;
    logic             w_in_hs;
    logic             w_last_word;
    logic             w_sync_load;
    logic             w_frame_done;

    assign s_axis_tready = (r_state == PAYLOAD) && w_load_ok;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_last_word   = (r_word_cnt == c_LAST_IDX);
    assign w_sync_load   = (r_state == IDLE) && s_axis_tvalid && w_load_ok;
    assign w_frame_done  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        w_header                  = '0;
        w_header[SEQ_LSB +: 16]   = r_seq;
        w_header[LEN_LSB +: 16]   = c_LEN;
    end

`ifdef AXIS_FRAMER_CHECKSUM_EN
    logic [WIDTH-1:0] r_csum;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_csum <= '0;
        end else if (w_sync_load) begin
            r_csum <= '0;
        end else if (w_in_hs) begin
            r_csum <= r_csum + s_axis_tdata;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ld_valid   = 1'b0;
        w_ld_last    = 1'b0;
        w_ld_data    = '0;
        case (r_state)
            IDLE: begin
                // Loading with valid low drains the register when no payload is pending
                if (w_load_ok) begin
                    w_load = 1'b1;
                    if (s_axis_tvalid) begin
                        w_ld_valid   = 1'b1;
                        w_ld_data    = WIDTH'(SYNC_WORD);
                        w_state_next = HEADER;
                    end
                end
            end
            HEADER: begin
                if (w_load_ok) begin
                    w_load       = 1'b1;
                    w_ld_valid   = 1'b1;
                    w_ld_data    = w_header;
                    w_state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_in_hs) begin
                    w_load     = 1'b1;
                    w_ld_valid = 1'b1;
                    w_ld_data  = s_axis_tdata;
                    if (w_last_word) begin
`ifdef AXIS_FRAMER_CHECKSUM_EN
                        w_state_next = TRAILER;
`else
                        w_ld_last    = 1'b1;
                        w_state_next = IDLE;
`endif
                    end
                end else if (m_axis_tready) begin
                    w_load = 1'b1;
                end
            end
`ifdef AXIS_FRAMER_CHECKSUM_EN
            TRAILER: begin
                if (w_load_ok) begin
                    w_load       = 1'b1;
                    w_ld_valid   = 1'b1;
                    w_ld_data    = r_csum;
                    w_ld_last    = 1'b1;
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= IDLE;
            r_word_cnt    <= '0;
            r_seq         <= '0;
            r_frame_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_sync_load) begin
                r_word_cnt <= '0;
            end else if (w_in_hs) begin
                r_word_cnt <= r_word_cnt + 16'd1;
            end
            // Counting on the tlast handshake lets the next header see the new seq
            if (w_frame_done) begin
                r_seq         <= r_seq + 16'd1;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign frame_count = r_frame_count;

    axis_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (aclk),
        .rst_n     (aresetn),
        .i_load    (w_load),
        .i_valid   (w_ld_valid),
        .i_data    (w_ld_data),
        .i_last    (w_ld_last),
        .i_tready  (m_axis_tready),
        .o_tvalid  (m_axis_tvalid),
        .o_tdata   (m_axis_tdata),
        .o_tlast   (m_axis_tlast),
        .o_load_ok (w_load_ok)
    );

endmodule
`default_nettype wire

// File: tb/tb_axis_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_framer
// Brief    : Directed self-checking bench for axis_framer (PAYLOAD_LEN = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_framer;

    localparam int WIDTH = 32;
    localparam int LEN   = 4;
`ifdef AXIS_FRAMER_CHECKSUM_EN
    localparam int FRAME_WORDS = LEN + 3;
`else
    localparam int FRAME_WORDS = LEN + 2;
`endif

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [WIDTH-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [15:0]      frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] src_q[$];
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    bit          gap_mode = 1'b0;
    int          cur_streak = 0;
    int          max_streak = 0;

    axis_framer #(
        .WIDTH       (WIDTH),
        .PAYLOAD_LEN (LEN),
        .SYNC_WORD   (32'h1ACFFC1D)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_count   (frame_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Source: holds a word until it is accepted; in gap mode valid is offered every other cycle
    initial begin : drv
        bit          hs;
        bit          phase;
        logic [31:0] dummy;
        phase         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        forever begin
            @(negedge aclk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge aclk);
            #1;
            if (hs && src_q.size() > 0) dummy = src_q.pop_front();
            phase = ~phase;
            if (src_q.size() > 0 && (!gap_mode || phase)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0];
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = '0;
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid) begin
            cur_streak++;
            if (cur_streak > max_streak) max_streak = cur_streak;
        end else begin
            cur_streak = 0;
        end
        if (aresetn && m_axis_tvalid && m_axis_tready)
            out_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic push_frame(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        src_q.push_back(a);
        src_q.push_back(b);
        src_q.push_back(c);
        src_q.push_back(d);
    endtask

    task automatic expect_frame(input logic [15:0] seq, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d, input logic [31:0] csum);
        exp_q.push_back({1'b0, 32'h1ACFFC1D});
        exp_q.push_back({1'b0, seq, 16'd4});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
`ifdef AXIS_FRAMER_CHECKSUM_EN
        exp_q.push_back({1'b0, d});
        exp_q.push_back({1'b1, csum});
`else
        exp_q.push_back({1'b1, d});
        if (csum === 32'hx) exp_q.push_back('0);
`endif
    endtask

    task automatic wait_and_compare(input string tag);
        int          n;
        int          t;
        logic [32:0] e;
        logic [32:0] o;
        n = exp_q.size();
        t = 0;
        while (out_q.size() < n && t < 400) begin
            @(negedge aclk);
            t++;
        end
        check({tag, "_count"}, 64'(out_q.size()), 64'(n));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (out_q.size() > 0) ? out_q.pop_front() : 33'hx;
            check(tag, o, e);
        end
    endtask

    task automatic check_frame_count(input string tag, input logic [15:0] exp);
        repeat (3) @(negedge aclk);
        check(tag, frame_count, exp);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;
        int t;
        m_axis_tready = 1'b1;
        aresetn       = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_sready", s_axis_tready, 0);
        check("rst_fcount", frame_count, 0);
        aresetn = 1'b1;

        // Single frame, sink always ready
        push_frame(32'd1, 32'd2, 32'd3, 32'd4);
        expect_frame(16'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
        wait_and_compare("single");
        check_frame_count("single_fcount", 16'd1);
        check("single_idle_tvalid", m_axis_tvalid, 0);

        // Three frames back to back
        push_frame(32'h10, 32'h11, 32'h12, 32'h13);
        push_frame(32'h14, 32'h15, 32'h16, 32'h17);
        push_frame(32'h18, 32'h19, 32'h1A, 32'h1B);
        expect_frame(16'd1, 32'h10, 32'h11, 32'h12, 32'h13, 32'h46);
        expect_frame(16'd2, 32'h14, 32'h15, 32'h16, 32'h17, 32'h56);
        expect_frame(16'd3, 32'h18, 32'h19, 32'h1A, 32'h1B, 32'h66);
        wait_and_compare("b2b");
        check("b2b_streak", 64'(max_streak), 64'(3 * FRAME_WORDS));
        check_frame_count("b2b_fcount", 16'd4);

        // Sink stall while payload word 2 is presented
        push_frame(32'd1, 32'd2, 32'd3, 32'd4);
        expect_frame(16'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0000000A);
        found = 1'b0;
        t     = 0;
        while (!found && t < 50) begin
            @(negedge aclk);
            found = m_axis_tvalid && (m_axis_tdata == 32'd1);
            t++;
        end
        check("stall_reach", found, 1);
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            check("stall_tdata", m_axis_tdata, 32'd2);
            check("stall_tvalid", m_axis_tvalid, 1);
            check("stall_sready", s_axis_tready, 0);
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
        wait_and_compare("stall");
        check_frame_count("stall_fcount", 16'd5);

        // Source gaps; nothing starts while the source is idle
        @(posedge aclk);
        #1;
        gap_mode = 1'b1;
        repeat (4) @(negedge aclk);
        check("gap_idle_tvalid", m_axis_tvalid, 0);
        push_frame(32'hA0, 32'hB0, 32'hC0, 32'hD0);
        expect_frame(16'd5, 32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'h000002E0);
        wait_and_compare("gap");
        check_frame_count("gap_fcount", 16'd6);
        @(posedge aclk);
        #1;
        gap_mode = 1'b0;

        // Checksum wraps modulo 2^32: FFFFFFFF+2+3+4 = 8
        push_frame(32'hFFFFFFFF, 32'd2, 32'd3, 32'd4);
        expect_frame(16'd6, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd4, 32'h00000008);
        wait_and_compare("csum");
        check_frame_count("csum_fcount", 16'd7);

        // Reset mid-frame after payload word 2
        push_frame(32'd1, 32'd2, 32'd3, 32'd4);
        t = 0;
        while (out_q.size() < 4 && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check("rstmid_reach", 64'(out_q.size() >= 4), 1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        src_q.delete();
        #1;
        check("rstmid_tvalid", m_axis_tvalid, 0);
        check("rstmid_tdata", m_axis_tdata, 0);
        check("rstmid_tlast", m_axis_tlast, 0);
        check("rstmid_sready", s_axis_tready, 0);
        check("rstmid_fcount", frame_count, 0);
        repeat (2) @(posedge aclk);
        #1;
        out_q.delete();
        aresetn = 1'b1;

        push_frame(32'd5, 32'd6, 32'd7, 32'd8);
        expect_frame(16'd0, 32'd5, 32'd6, 32'd7, 32'd8, 32'h0000001A);
        wait_and_compare("post_rst");
        check_frame_count("post_rst_fcount", 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
